// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared definitions for the multiplexed 7-segment scan controller:
//            register map, CTRL field positions, segment encoding table,
//            register reset values and the per-slot snapshot record.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Register map (2-bit word address)
  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_DP   = 2'd1,
    REG_CTRL = 2'd2,
    REG_RSVD = 2'd3
  } reg_addr_e;

  // CTRL field positions
  localparam int c_CTRL_EN_BIT     = 0;
  localparam int c_CTRL_LZB_BIT    = 1;
  localparam int c_CTRL_BRIGHT_LSB = 4;

  // Active-high {g,f,e,d,c,b,a} pattern for hex digits 0..F, entry [n] = digit n
  localparam logic [15:0][6:0] c_SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Register reset values
  localparam logic [31:0] c_RST_DATA   = 32'h0000_0000;
  localparam logic [7:0]  c_RST_DP     = 8'h00;
  localparam logic        c_RST_EN     = 1'b1;
  localparam logic        c_RST_LZB    = 1'b0;
  localparam logic [3:0]  c_RST_BRIGHT = 4'hF;

  // Everything needed to drive one digit slot, frozen at the slot start
  typedef struct packed {
    logic       en;
    logic       blank;   // segments a..g suppressed (leading zero)
    logic       dp;
    logic [3:0] bright;
    logic [3:0] nibble;
  } slot_snap_t;

  localparam slot_snap_t c_RST_SNAP = '{
    en:     c_RST_EN,
    blank:  1'b0,
    dp:     1'b0,
    bright: c_RST_BRIGHT,
    nibble: 4'h0
  };

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_7seg
// Purpose  : Combinational hex nibble to 7-segment decoder, active-high
//            output (bit 0 = segment a ... bit 6 = segment g).
// Ports    : hex  in  4  nibble to display
//            seg  out 7  segment pattern {g..a}, 1 = segment lit
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = c_SEG_LUT[hex];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : Bus-writable multiplexed 7-segment display controller with
//            programmable digit count, scan rate, inter-digit blanking,
//            16-level brightness PWM, decimal points and leading-zero blanking.
// Ports    : clk       in  1           system clock
//            reset_n   in  1           asynchronous active-low reset
//            wr_en     in  1           register write strobe
//            wr_addr   in  2           write register address
//            wr_data   in  32          write data
//            rd_addr   in  2           read register address
//            rd_data   out 32          read data, one cycle after rd_addr
//            seg_data  out 8           {dp, g..a}
//            seg_com   out NUM_DIGITS  digit select, bit 0 = rightmost digit
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int CLK_HZ         = 125000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYC      = 1250,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [1:0]            wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [1:0]            rd_addr,
  output logic [31:0]           rd_data,
  output logic [7:0]            seg_data,
  output logic [NUM_DIGITS-1:0] seg_com
);

  localparam int c_SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int c_STEP     = (c_SLOT_CYC - BLANK_CYC) / 16;
  localparam int c_CNT_W    = $clog2(c_SLOT_CYC);
  localparam int c_IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_DATA_W   = 4 * NUM_DIGITS;

  localparam logic [c_CNT_W-1:0]    c_CNT_MAX = c_CNT_W'(c_SLOT_CYC - 1);
  localparam logic [c_IDX_W-1:0]    c_IDX_MAX = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [31:0]           c_BLANK   = 32'(BLANK_CYC);
  localparam logic [31:0]           c_STEP32  = 32'(c_STEP);
  localparam logic [7:0]            c_SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] c_COM_OFF = COM_ACTIVE_LOW ? '1 : '0;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [c_DATA_W-1:0]   r_data;
  logic [NUM_DIGITS-1:0] r_dp;
  logic                  r_en;
  logic                  r_lzb;
  logic [3:0]            r_bright;
  logic [31:0]           r_rd_data;
  logic [31:0]           w_rd_mux;

  // Bits of wr_data above the implemented register width are intentionally dropped
  logic w_unused_wr;
  assign w_unused_wr = &{1'b0, wr_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= c_RST_DATA[c_DATA_W-1:0];
      r_dp     <= c_RST_DP[NUM_DIGITS-1:0];
      r_en     <= c_RST_EN;
      r_lzb    <= c_RST_LZB;
      r_bright <= c_RST_BRIGHT;
    end else if (wr_en) begin
      case (wr_addr)
        REG_DATA: r_data <= wr_data[c_DATA_W-1:0];
        REG_DP:   r_dp   <= wr_data[NUM_DIGITS-1:0];
        REG_CTRL: begin
          r_en     <= wr_data[c_CTRL_EN_BIT];
          r_lzb    <= wr_data[c_CTRL_LZB_BIT];
          r_bright <= wr_data[c_CTRL_BRIGHT_LSB +: 4];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (rd_addr)
      REG_DATA: w_rd_mux[c_DATA_W-1:0]   = r_data;
      REG_DP:   w_rd_mux[NUM_DIGITS-1:0] = r_dp;
      REG_CTRL: begin
        w_rd_mux[c_CTRL_EN_BIT]            = r_en;
        w_rd_mux[c_CTRL_LZB_BIT]           = r_lzb;
        w_rd_mux[c_CTRL_BRIGHT_LSB +: 4]   = r_bright;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd_data <= '0;
    else          r_rd_data <= w_rd_mux;
  end

  assign rd_data = r_rd_data;

  // --------------------------------------------------------------------------
  // Scan counters
  // --------------------------------------------------------------------------
  logic [c_CNT_W-1:0] r_slot_cnt;
  logic [c_IDX_W-1:0] r_digit_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (r_slot_cnt == c_CNT_MAX) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= (r_digit_idx == c_IDX_MAX) ? '0 : r_digit_idx + 1'b1;
    end else begin
      r_slot_cnt  <= r_slot_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero detection: bit i set when nibbles i..NUM_DIGITS-1 are all
  // zero. Bit 0 stays clear so the rightmost digit always shows.
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] w_lz_blank;

  always_comb begin
    logic w_all_zero;
    w_lz_blank = '0;
    w_all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_all_zero    = w_all_zero && (r_data[4*i +: 4] == 4'd0);
      w_lz_blank[i] = w_all_zero;
    end
  end

  // --------------------------------------------------------------------------
  // Per-slot snapshot. It is captured while slot_cnt==0, so a write landing
  // in that same cycle only affects the following slot. During slot_cnt==0
  // itself the live values are used directly so the slot never starts from
  // the previous digit's data.
  // --------------------------------------------------------------------------
  slot_snap_t w_live;
  slot_snap_t r_snap;
  slot_snap_t w_cur;
  logic       w_slot_start;

  assign w_slot_start = (r_slot_cnt == '0);

  always_comb begin
    w_live        = c_RST_SNAP;
    w_live.en     = r_en;
    w_live.blank  = r_lzb & w_lz_blank[r_digit_idx];
    w_live.dp     = r_dp[r_digit_idx];
    w_live.bright = r_bright;
    w_live.nibble = r_data[{r_digit_idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_snap <= c_RST_SNAP;
    else if (w_slot_start) r_snap <= w_live;
  end

  assign w_cur = w_slot_start ? w_live : r_snap;

  // --------------------------------------------------------------------------
  // PWM window: lit from BLANK_CYC for STEP*(bright+1) cycles of the slot
  // --------------------------------------------------------------------------
  logic [31:0] w_slot32;
  logic [31:0] w_on_end;
  logic        w_on;

  assign w_slot32 = 32'(r_slot_cnt);
  assign w_on_end = c_BLANK + c_STEP32 * (32'(w_cur.bright) + 32'd1);
  assign w_on     = w_cur.en && (w_slot32 >= c_BLANK) && (w_slot32 < w_on_end);

  // --------------------------------------------------------------------------
  // Output drive (registered, one cycle behind the counters)
  // --------------------------------------------------------------------------
  logic [6:0]            w_seg_hex;
  logic [7:0]            w_seg_lit;
  logic [NUM_DIGITS-1:0] w_com_lit;
  logic [7:0]            r_seg_data;
  logic [NUM_DIGITS-1:0] r_seg_com;

  hex_to_7seg u_hex_to_7seg (
    .hex (w_cur.nibble),
    .seg (w_seg_hex)
  );

  // A blanked digit keeps its decimal point
  assign w_seg_lit = {w_cur.dp, (w_cur.blank ? 7'd0 : w_seg_hex)};
  assign w_com_lit = NUM_DIGITS'(1) << r_digit_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg_data <= c_SEG_OFF;
      r_seg_com  <= c_COM_OFF;
    end else if (w_on) begin
      r_seg_data <= SEG_ACTIVE_LOW ? ~w_seg_lit : w_seg_lit;
      r_seg_com  <= COM_ACTIVE_LOW ? ~w_com_lit : w_com_lit;
    end else begin
      r_seg_data <= c_SEG_OFF;
      r_seg_com  <= c_COM_OFF;
    end
  end

  assign seg_data = r_seg_data;
  assign seg_com  = r_seg_com;

endmodule
`default_nettype wire
